blink: RTL and testbench
========================

# blink

Free-running LED blinker used as the minimal device-under-test for on-chip logic-analyser bring-up. A core clock drives a binary counter, and the counter MSB drives the `led` pin. This gives a visible square wave on hardware and a short, predictable waveform in simulation. An optional vendor PLL stage can be compiled in to derive the core clock from the board reference.

## Interface
- `CNT_WIDTH`, default 26: counter width in bits, legal range 2..32. `led` toggles every 2^(CNT_WIDTH-1) core clocks.
- `clk`, input, 1 bit: board reference clock, rising-edge. It is the core clock unless the PLL is compiled in.
- `rst`, input, 1 bit: reset. Asynchronous and active-high.
- `led`, output, 1 bit: blink output, registered.

## Operation
- Reset synchronizer:
  - `rst` asserts internal reset `rst_core` immediately, with no clock needed.
  - Deassertion passes through two core-clock flops, so `rst_core` falls on the 2nd rising edge after `rst` falls.
- Counter `cnt[CNT_WIDTH-1:0]`:
  - Cleared to 0 while `rst_core` = 1.
  - Otherwise increments by 1 on every rising core-clock edge.
  - Unsigned modulo 2^CNT_WIDTH: all-ones wraps to 0 with no stall.
- `led` is a flop loaded with the next value of `cnt[CNT_WIDTH-1]`, so `led` always equals the MSB of the current counter value.
- Reset value of `led` is 0. `led` is forced to 0 asynchronously whenever `rst` = 1.
- Reset mid-operation: `led` and `cnt` clear immediately. After release, counting restarts from 0 with the same latency as after power-up.
- There are no other inputs and no other modes.

## Timing
- Latency after `rst` falls:
  - Edges 1–2: synchronizer release; `cnt` stays 0.
  - Edge 3: `cnt` = 1.
  - Edge N: `cnt` = N−2.
- First `led` rise occurs on rising edge 2^(CNT_WIDTH-1)+2 after release.
- Steady state:
  - `led` period is 2^CNT_WIDTH core clocks with exactly 50 % duty.
  - Each edge is aligned to a core-clock rising edge.
- `rst` assertion to `led` = 0 is combinational through the async clear, with no clock edge required.

## Configuration
- Macro `BLINK_PLL_EN`.
- **Defined:**
  - A CC_PLL is instantiated with REF_CLK "10.0", OUT_CLK "100.0", PERF_MD "ECONOMY".
  - `clk` drives CLK_REF, and CLK0 is the core clock for the synchronizer, counter and `led`.
  - The lock outputs are left unconnected and do not gate counting.
  - USR_CLK_REF, CLK_FEEDBACK, USR_LOCKED_STDY_RST and USR_SET_SEL are tied to 0.
- **Undefined:** no PLL. `clk` is the core clock directly.
- Port list and reset behaviour are identical in both builds.

## Structure
- Package `blink_pkg` holds:
  - `CNT_WIDTH_DEFAULT` = 26.
  - PLL string constants `PLL_REF_MHZ` = "10.0" and `PLL_OUT_MHZ` = "100.0".
- Sub-module `blink_rst_sync`:
  - 2-flop async-assert / sync-deassert synchronizer.
  - Ports `clk`, `rst_in`, `rst_out`, all active-high.
- The top `blink` contains the optional PLL, the counter and the `led` flop.

## Test plan
Common setup for all scenarios: `CNT_WIDTH` = 4, `BLINK_PLL_EN` undefined, `clk` period 2 ns.
- **Hold in reset:** hold `rst` = 1 for 200 ns → `led` = 0 and `cnt` = 0 throughout.
- **Release latency:** drop `rst` at a falling `clk` edge →
  - `cnt` = 0 after rising edges 1–2.
  - `cnt` = 1 after edge 3.
  - `led` first goes 1 on edge 10 (`cnt` = 8).
- **Steady state:** run 500 ns → `led` period 32 ns, high 16 ns, low 16 ns.
- **Wrap:** `cnt` goes 15 → 0 on one edge, `led` falls on that same edge, and counting continues at 1.
- **Reset mid-operation:** assert `rst` while `led` = 1, between clock edges → `led` = 0 before the next `clk` edge. Release → first `led` rise again 10 edges later.
- **PLL build:** define `BLINK_PLL_EN` and use the behavioural CC_PLL model → `led` toggles every 8 CLK0 cycles, and the release latency is counted in CLK0 edges.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants for the blink LED blinker.
// Optional PLL stage selected with macro BLINK_PLL_EN; PLL frequency strings live here.
package blink_pkg;

    // Default counter width: led toggles every 2^25 core clocks.
    localparam int CNT_WIDTH_DEFAULT = 26;

    // Vendor PLL frequency settings, in MHz, as the primitive expects them.
    localparam PLL_REF_MHZ = "10.0";
    localparam PLL_OUT_MHZ = "100.0";

endpackage : blink_pkg

// File: rtl/blink_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second rising clk edge after rst_in falls. All signals active-high.
module blink_rst_sync (
    input  logic clk,
    input  logic rst_in,
    output logic rst_out
);

    logic [1:0] sync_q;

    // Shift zeros in once rst_in is low; rst_in forces both stages high at once.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_out = sync_q[1];

endmodule : blink_rst_sync

// File: rtl/blink.sv
// Free-running LED blinker: a binary counter whose MSB drives led.
// Build option: define BLINK_PLL_EN to derive the core clock from clk
// through a CC_PLL (10 MHz in, 100 MHz out); otherwise clk is the core clock.
module blink
    import blink_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic led
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 core_clk;
    logic                 rst_core;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;

`ifdef BLINK_PLL_EN
    // Lock outputs are deliberately ignored: counting runs as soon as CLK0 toggles.
    CC_PLL #(
        .REF_CLK (PLL_REF_MHZ),
        .OUT_CLK (PLL_OUT_MHZ),
        .PERF_MD ("ECONOMY")
    ) pll_i (
        .CLK_REF             (clk),
        .USR_CLK_REF         (1'b0),
        .CLK_FEEDBACK        (1'b0),
        .USR_LOCKED_STDY_RST (1'b0),
        .USR_SET_SEL         (1'b0),
        .CLK0                (core_clk),
        .CLK90               (),
        .CLK180              (),
        .CLK270              (),
        .CLK_REF_OUT         (),
        .USR_PLL_LOCKED_STDY (),
        .USR_PLL_LOCKED      ()
    );
`else
    assign core_clk = clk;
`endif

    blink_rst_sync rst_sync_i (
        .clk     (core_clk),
        .rst_in  (rst),
        .rst_out (rst_core)
    );

    // Modulo 2^CNT_WIDTH increment; all-ones wraps to zero naturally.
    assign cnt_next = cnt + CNT_ONE;

    // Counter and led flop share the reset; led takes the MSB of the value
    // cnt is about to hold, so it always mirrors the current counter MSB.
    always_ff @(posedge core_clk or posedge rst_core) begin
        if (rst_core) begin
            cnt <= '0;
            led <= 1'b0;
        end else begin
            cnt <= cnt_next;
            led <= cnt_next[CNT_WIDTH-1];
        end
    end

endmodule : blink

// File: tb/tb_blink.sv
`timescale 1ns/1ps
module tb_blink;

    localparam int W = 4;

    logic clk;
    logic rst;
    logic led;

    int checks;
    int errors;

    // Number of rising edges seen since rst was last released.
    int  edge_k;
    bit  steady_en;
    real t_rise;
    real t_fall;
    bit  have_rise;
    bit  have_fall;

    blink #(.CNT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .led (led)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #1 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour from the timing rules: two release edges hold cnt at 0,
    // then edge N gives cnt = N-2 modulo 2^W; led is the counter MSB.
    function automatic int model_cnt(input int k);
        if (k <= 2) return 0;
        return (k - 2) % (1 << W);
    endfunction

    function automatic int model_led(input int k);
        return (model_cnt(k) >= (1 << (W - 1))) ? 1 : 0;
    endfunction

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        if (rst) edge_k = 0;
        else     edge_k = edge_k + 1;
        #0.5;
        chk("cycle_cnt", int'(dut.cnt), rst ? 0 : model_cnt(edge_k));
        chk("cycle_led", int'(led),     rst ? 0 : model_led(edge_k));
    end

    // ---------------- led waveform measurement ----------------
    always @(posedge led) begin
        if (steady_en && have_fall)
            chk("low_ps", int'(($realtime - t_fall) * 1000.0), 16000);
        if (steady_en && have_fall && have_rise)
            chk("period_ps", int'(($realtime - t_rise) * 1000.0), 32000);
        t_rise = $realtime;
        have_rise = 1'b1;
    end

    always @(negedge led) begin
        if (steady_en && have_rise && !rst)
            chk("high_ps", int'(($realtime - t_rise) * 1000.0), 16000);
        t_fall = $realtime;
        have_fall = 1'b1;
    end

    // Wait (bounded) for the next rising edge after which led reads 1.
    task automatic wait_led_rise(input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            @(posedge clk);
            #0.5;
            edges++;
            if (led) return;
        end
        chk("led_rise_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        checks = 0;
        errors = 0;
        edge_k = 0;
        steady_en = 1'b0;
        have_rise = 1'b0;
        have_fall = 1'b0;
        rst = 1'b1;

        // Hold in reset: compare process checks led/cnt = 0 every cycle.
        #200;
        chk("hold_led", int'(led), 0);
        chk("hold_cnt", int'(dut.cnt), 0);

        // Release latency, rst dropped at a falling edge.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #0.5;
        chk("rel_e1_cnt", int'(dut.cnt), 0);
        @(posedge clk); #0.5;
        chk("rel_e2_cnt", int'(dut.cnt), 0);
        @(posedge clk); #0.5;
        chk("rel_e3_cnt", int'(dut.cnt), 1);
        repeat (6) @(posedge clk);
        #0.5;
        chk("rel_e9_led", int'(led), 0);
        @(posedge clk); #0.5;
        chk("rel_e10_led", int'(led), 1);
        chk("rel_e10_cnt", int'(dut.cnt), 8);

        // Wrap: edge 17 -> 15, edge 18 -> 0 with led falling, edge 19 -> 1.
        repeat (7) @(posedge clk);
        #0.5;
        chk("wrap_e17_cnt", int'(dut.cnt), 15);
        chk("wrap_e17_led", int'(led), 1);
        @(posedge clk); #0.5;
        chk("wrap_e18_cnt", int'(dut.cnt), 0);
        chk("wrap_e18_led", int'(led), 0);
        @(posedge clk); #0.5;
        chk("wrap_e19_cnt", int'(dut.cnt), 1);

        // Steady state: 500 ns of 16 ns high / 16 ns low.
        steady_en = 1'b1;
        #500;
        steady_en = 1'b0;

        // Reset mid-operation while led = 1, between clock edges.
        wait_led_rise(40, n);
        @(negedge clk);
        #0.5;
        rst = 1'b1;
        #0.2;
        chk("mid_led_async", int'(led), 0);
        chk("mid_cnt_async", int'(dut.cnt), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_led_rise(40, n);
        chk("mid_rise_edges", n, 10);

        repeat (4) @(posedge clk);
        #0.5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case stimulus stalls.
    initial begin
        #20000;
        errors++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_blink
